mem_port_arbiter: RTL

Shares the single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined RV32 core. Owns a small request/grant FSM, stalls the losing stage, and feeds `if_stall` / `mem_stall` to the hazard detection unit, which gates `pcWrite` / `ifIdWrite` and freezes the later pipeline registers. Fetches in flight are killed when the hazard detection unit raises `IFflush`.

---
 rtl/rv32_mem_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types for the IF/MEM memory port arbiter of the RV32 core.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// load/store, with a bounded data burst so a waiting fetch cannot starve.
module mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_ack,
    input  logic [31:0]       m_rdata
);

    arb_state_t state_q, state_d;
    logic [3:0] d_cnt_q, d_cnt_d;
    logic       discard_q, discard_d;
    mem_req_t   m_q, m_d;
    logic       fetch_ok, fetch_win, data_win;

    always_comb begin
        state_d   = state_q;
        d_cnt_d   = d_cnt_q;
        discard_d = discard_q;
        m_d       = m_q;
        fetch_ok  = i_req & ~i_kill;
        fetch_win = 1'b0;
        data_win  = 1'b0;
        case (state_q)
            IDLE: begin
                // Data normally wins; a fetch that has waited out a full burst goes first.
                fetch_win = fetch_ok & (~d_req | (d_cnt_q == 4'(MAX_D_BURST)));
                data_win  = d_req & ~fetch_win;
                if (data_win) begin
                    state_d = BUSY_D;
                    m_d     = '{we: d_we, be: d_be, addr: 32'(d_addr), wdata: d_wdata};
                    if (fetch_ok)
                        d_cnt_d = (d_cnt_q == 4'hF) ? d_cnt_q : d_cnt_q + 4'd1;
                    else if (!i_req)
                        d_cnt_d = '0;
                end else if (fetch_win) begin
                    state_d = BUSY_I;
                    m_d     = '{we: 1'b0, be: FETCH_BE, addr: 32'(i_addr), wdata: '0};
                    d_cnt_d = '0;
                end
            end
            BUSY_I: begin
                // The memory cannot abort, so a killed fetch runs to ack and is dropped.
                if (m_ack) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end else if (i_kill) begin
                    discard_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (m_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            d_cnt_q   <= '0;
            discard_q <= 1'b0;
            m_q       <= '0;
        end else begin
            state_q   <= state_d;
            d_cnt_q   <= d_cnt_d;
            discard_q <= discard_d;
            m_q       <= m_d;
        end
    end

    assign m_req     = (state_q != IDLE);
    assign m_we      = m_q.we;
    assign m_be      = m_q.be;
    assign m_addr    = m_q.addr[ADDR_W-1:0];
    assign m_wdata   = m_q.wdata;

    assign i_ready   = (state_q == BUSY_I) & m_ack & ~discard_q;
    assign d_ready   = (state_q == BUSY_D) & m_ack;
    assign i_rdata   = i_ready ? m_rdata : '0;
    assign d_rdata   = d_ready ? m_rdata : '0;

    assign if_stall  = i_req & ~i_ready;
    assign mem_stall = d_req & ~d_ready;

endmodule
